// File: rtl/axi_slave_read_pkg.sv
// Shared AXI4 slave-side definitions: channel widths, burst/response encodings
// and the responder state encoding used by the read (and later write) slaves.
package axi_slave_read_pkg;

   localparam int AXI_ID_W   = 8;
   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_LEN_W  = 4;
   localparam int AXI_SIZE_W = 3;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Widest beat the 32-bit SRAM can serve (4 bytes)
   localparam logic [AXI_SIZE_W-1:0] SIZE_MAX = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2
   } slv_state_e;

endpackage

// File: rtl/axi_slave_read.sv
// AXI4 AR/R responder in front of a single-port word SRAM: one outstanding
// burst, one SRAM fetch per beat, so a beat costs a FETCH and a SEND cycle.
module axi_slave_read
   import axi_slave_read_pkg::*;
#(
   parameter int ID_W   = 8,
   parameter int MEM_AW = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ID_W-1:0]       ARID,
   input  logic [AXI_ADDR_W-1:0] ARADDR,
   input  logic [AXI_LEN_W-1:0]  ARLEN,
   input  logic [AXI_SIZE_W-1:0] ARSIZE,
   input  logic [1:0]            ARBURST,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   output logic [ID_W-1:0]       RID,
   output logic [AXI_DATA_W-1:0] RDATA,
   output logic [1:0]            RRESP,
   output logic                  RLAST,
   output logic                  RVALID,
   input  logic                  RREADY,
   output logic                  mem_cs,
   output logic                  mem_oe,
   output logic [MEM_AW-1:0]     mem_addr,
   input  logic [AXI_DATA_W-1:0] mem_rdata
);

   slv_state_e            state_q;
   logic [ID_W-1:0]       id_q;
   logic [MEM_AW-1:0]     addr_q;
   logic [AXI_LEN_W-1:0]  len_q;
   logic [AXI_LEN_W-1:0]  cnt_q;
   logic                  fixed_q;
   logic                  err_q;
   logic                  beat_last;
   logic                  in_send;
   logic                  unused_addr_bits;

   // Byte lane and bits above the SRAM window carry no meaning here
   assign unused_addr_bits = ^{ARADDR[AXI_ADDR_W-1:MEM_AW+2], ARADDR[1:0]};

   assign beat_last = (cnt_q == len_q);
   assign in_send   = (state_q == ST_SEND);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         fixed_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ARVALID) begin
                  id_q    <= ARID;
                  addr_q  <= ARADDR[MEM_AW+1:2];
                  len_q   <= ARLEN;
                  fixed_q <= (ARBURST == BURST_FIXED);
                  err_q   <= (ARSIZE > SIZE_MAX);
                  cnt_q   <= '0;
                  state_q <= ST_FETCH;
               end
            end
            ST_FETCH: state_q <= ST_SEND;
            ST_SEND: begin
               if (RREADY) begin
                  if (beat_last) begin
                     state_q <= ST_IDLE;
                  end else begin
                     cnt_q   <= cnt_q + 4'd1;
                     // WRAP is served as INCR; the word address rolls over silently
                     if (!fixed_q)
                        addr_q <= addr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
                     state_q <= ST_FETCH;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ARREADY  = (state_q == ST_IDLE);

   assign mem_cs   = (state_q == ST_FETCH) && !err_q;
   assign mem_oe   = mem_cs;
   assign mem_addr = addr_q;

   // SRAM holds its output while cs is low, so RDATA stays stable under a stall
   assign RVALID   = in_send;
   assign RID      = in_send ? id_q : '0;
   assign RDATA    = (in_send && !err_q) ? mem_rdata : '0;
   assign RRESP    = !in_send ? RESP_OKAY : (err_q ? RESP_SLVERR : RESP_OKAY);
   assign RLAST    = in_send && beat_last;

endmodule

// File: tb/tb_axi_slave_read.sv
// Scoreboard bench for axi_slave_read with a behavioural SRAM model.
module tb_axi_slave_read;

   localparam int ID_W   = 8;
   localparam int MEM_AW = 14;
   localparam int DEPTH  = 1 << MEM_AW;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [31:0]     data;
      logic [1:0]      resp;
      logic            last;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ID_W-1:0]   ARID = '0;
   logic [31:0]       ARADDR = '0;
   logic [3:0]        ARLEN = '0;
   logic [2:0]        ARSIZE = '0;
   logic [1:0]        ARBURST = '0;
   logic              ARVALID = 1'b0;
   logic              ARREADY;
   logic [ID_W-1:0]   RID;
   logic [31:0]       RDATA;
   logic [1:0]        RRESP;
   logic              RLAST;
   logic              RVALID;
   logic              RREADY = 1'b1;
   logic              mem_cs;
   logic              mem_oe;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_rdata = '0;

   logic [31:0]       mem [0:DEPTH-1];
   beat_t             exp_q [$];
   logic [MEM_AW-1:0] mem_q [$];
   int                n_checks = 0;
   int                n_errors = 0;
   int                beats_seen = 0;

   axi_slave_read #(.ID_W(ID_W), .MEM_AW(MEM_AW)) dut (
      .clk(clk), .rst(rst),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
      .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .RVALID(RVALID), .RREADY(RREADY),
      .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (mem_cs && mem_oe) mem_rdata <= mem[mem_addr];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Monitor: fetch addresses and R beats against the scoreboard
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         mem_q.delete();
      end else begin
         if (mem_cs) begin
            check("mem_oe", mem_oe, 1'b1);
            if (mem_q.size() == 0) check("unexp_mem_cs", 1'b1, 1'b0);
            else begin
               check("mem_addr", mem_addr, mem_q[0]);
               void'(mem_q.pop_front());
            end
         end
         if (RVALID) begin
            if (exp_q.size() == 0) check("unexp_rvalid", 1'b1, 1'b0);
            else begin
               check("rid", RID, exp_q[0].id);
               check("rdata", RDATA, exp_q[0].data);
               check("rresp", RRESP, exp_q[0].resp);
               check("rlast", RLAST, exp_q[0].last);
               if (RREADY) begin
                  void'(exp_q.pop_front());
                  beats_seen++;
               end
            end
         end
      end
   end

   task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst);
      logic [MEM_AW-1:0] base;
      logic [MEM_AW-1:0] a;
      logic              err;
      beat_t             b;
      int                w;
      err  = (size > 3'd2);
      base = addr[MEM_AW+1:2];
      for (int i = 0; i <= int'(len); i++) begin
         a = (burst == 2'b00) ? base : base + MEM_AW'(i);
         if (!err) mem_q.push_back(a);
         b.id   = id;
         b.data = err ? 32'h0 : mem[a];
         b.resp = err ? 2'b10 : 2'b00;
         b.last = (i == int'(len));
         exp_q.push_back(b);
      end
      w = 0;
      while (!ARREADY && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      check("arready_wait", ARREADY, 1'b1);
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
      ARVALID = 1'b1;
      @(posedge clk); #1;
      ARVALID = 1'b0;
      @(negedge clk);
      check("fetch_cs", mem_cs, !err);
      @(negedge clk);
      check("first_rvalid", RVALID, 1'b1);
   endtask

   task automatic wait_done();
      int w;
      w = 0;
      while ((exp_q.size() != 0 || mem_q.size() != 0) && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("done_timeout", w < 200, 1'b1);
   endtask

   task automatic wait_beat2(input int b0);
      int w;
      w = 0;
      do begin
         @(posedge clk); #1;
         w++;
      end while (!(RVALID && beats_seen == b0 + 1) && w < 50);
      check("beat2_timeout", w < 50, 1'b1);
   endtask

   initial begin
      int b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = {i[15:0] ^ 16'hA55A, ~i[15:0]};
      mem[4]  = 32'hDEAD_BEEF;
      mem[8]  = 32'd1;
      mem[9]  = 32'd2;
      mem[10] = 32'd3;
      mem[11] = 32'd4;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_arready", ARREADY, 1'b1);
      check("rst_rvalid", RVALID, 1'b0);
      check("rst_rlast", RLAST, 1'b0);
      check("rst_rresp", RRESP, 2'b00);
      check("rst_rid", RID, '0);
      check("rst_rdata", RDATA, '0);
      check("rst_mem_cs", mem_cs, 1'b0);
      check("rst_mem_oe", mem_oe, 1'b0);
      check("rst_mem_addr", mem_addr, '0);

      // Single read with latency checks
      do_read(8'h15, 32'h0000_0010, 4'd0, 3'd2, 2'b01);
      check("single_arready_busy", ARREADY, 1'b0);
      @(negedge clk);
      check("single_arready_back", ARREADY, 1'b1);
      wait_done();

      // INCR burst, beat 2 stalled for 3 cycles
      b0 = beats_seen;
      do_read(8'h21, 32'h0000_0020, 4'd3, 3'd2, 2'b01);
      wait_beat2(b0);
      RREADY = 1'b0;
      repeat (3) @(posedge clk);
      #1 RREADY = 1'b1;
      wait_done();
      check("incr_beats", beats_seen - b0, 4);

      // FIXED burst
      b0 = beats_seen;
      do_read(8'h33, 32'h0000_0040, 4'd2, 3'd2, 2'b00);
      wait_done();
      check("fixed_beats", beats_seen - b0, 3);

      // Address rollover with maximum length (WRAP served as INCR)
      b0 = beats_seen;
      do_read(8'h44, 32'(DEPTH - 2) << 2, 4'd15, 3'd2, 2'b10);
      wait_done();
      check("wrap_beats", beats_seen - b0, 16);

      // Oversized beat: SLVERR, no SRAM access
      b0 = beats_seen;
      do_read(8'h55, 32'h0000_0080, 4'd1, 3'd3, 2'b01);
      wait_done();
      check("err_beats", beats_seen - b0, 2);
      @(negedge clk);
      check("err_idle", ARREADY, 1'b1);

      // Reset during SEND of beat 2, then a clean single read
      b0 = beats_seen;
      do_read(8'h66, 32'h0000_0100, 4'd3, 3'd2, 2'b01);
      wait_beat2(b0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_rvalid", RVALID, 1'b0);
      check("midrst_arready", ARREADY, 1'b1);
      check("midrst_mem_cs", mem_cs, 1'b0);
      rst = 1'b0;
      b0 = beats_seen;
      do_read(8'h77, 32'h0000_0010, 4'd0, 3'd2, 2'b01);
      wait_done();
      check("post_rst_beats", beats_seen - b0, 1);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/axi_slave_read.md
Name: axi_slave_read

Overview:
- AXI4 read-channel responder (AR/R) that fronts a single-port word SRAM macro.
- It accepts one read address at a time and fetches each beat from the SRAM. It returns INCR or FIXED bursts of 1–16 beats with RID echoed.
- It is the slave-side counterpart of the CPU-side read masters. It sits behind the interconnect on IM/DM/ROM slave ports.
- Single outstanding transaction; no read interleaving.

Parameters:
- ID_W, 8, width of ARID/RID (interconnect-extended ID).
- MEM_AW, 14, SRAM word-address width (depth = 2^MEM_AW words).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ARID  in  ID_W  read transaction ID.
- ARADDR  in  32  byte address; bits [MEM_AW+1:2] select the word.
- ARLEN  in  4  beats-1.
- ARSIZE  in  3  beat size.
- ARBURST  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP.
- ARVALID  in  1  address valid.
- ARREADY  out  1  address accepted.
- RID  out  ID_W  echoed ID.
- RDATA  out  32  read data.
- RRESP  out  2  response: 00 OKAY, 10 SLVERR.
- RLAST  out  1  final beat.
- RVALID  out  1  data valid.
- RREADY  in  1  master accepts data.
- mem_cs  out  1  SRAM chip select.
- mem_oe  out  1  SRAM output enable.
- mem_addr  out  MEM_AW  SRAM word address.
- mem_rdata  in  32  SRAM data. Valid the cycle after a cs&oe cycle; held stable until the next access.

Behaviour:
- States: IDLE, FETCH, SEND.
- Reset (any state, including mid-burst): next edge state=IDLE and all internal registers 0.
- Output values in IDLE after reset:
  - ARREADY=1.
  - RVALID=0, RLAST=0, RRESP=00, RID=0, RDATA=0.
  - mem_cs=0, mem_oe=0, mem_addr=0.
- ARREADY = (state==IDLE), combinational.
- IDLE:
  - On ARVALID&ARREADY, latch id, word addr = ARADDR[MEM_AW+1:2], len, burst type, and err = (ARSIZE > 3'b010).
  - Clear beat counter cnt; go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - mem_cs=mem_oe=!err; mem_addr=latched word addr; RVALID=0.
  - Always go to SEND next cycle. An error transaction issues no SRAM access.
- SEND:
  - RVALID=1, RID=latched id.
  - RDATA = err ? 0 : mem_rdata.
  - RRESP = err ? 10 : 00.
  - RLAST = (cnt==len).
  - mem_cs=mem_oe=0, so mem_rdata is held.
  - All R outputs stay stable while RVALID&!RREADY (no limit on stall length).
  - On RREADY with RLAST: go to IDLE. ARREADY rises the next cycle, so new AR acceptance is at least 1 idle cycle after the last handshake.
  - On RREADY without RLAST: cnt+=1; word addr += 1 for INCR/WRAP, unchanged for FIXED; go to FETCH.
- Address arithmetic:
  - MEM_AW-bit increment; wraps from 2^MEM_AW-1 to 0 with no error.
  - WRAP bursts are treated as INCR.
- Latency and throughput:
  - AR handshake at cycle T → first RVALID at T+2.
  - Each subsequent beat comes 2 cycles after the previous R handshake.
  - Peak throughput is 1 beat / 2 cycles.
- cnt is 4 bits. ARLEN=15 gives 16 beats; cnt never overflows because RLAST ends the burst at cnt==15.
- Error bursts return exactly len+1 beats, all SLVERR, RDATA=0.
- ARVALID changes while not in IDLE are ignored. ARADDR[1:0] is ignored (word aligned).
- RVALID, RLAST and RDATA never depend combinationally on RREADY. RDATA depends only on state and mem_rdata.

Decomposition:
- Shared AXI package holds:
  - widths: ID, ADDR=32, DATA=32, LEN=4, SIZE=3.
  - burst encodings: FIXED/INCR/WRAP.
  - RRESP codes: OKAY/EXOKAY/SLVERR/DECERR.
  - state enum {IDLE, FETCH, SEND}.
- Single flat module; no sub-module needed.
- A later AW/W/B responder, axi_slave_write, shares the package, and an axi_slave wrapper instantiates both.

Test Plan:
- Reset mid-burst: reset asserted during SEND of beat 2 → next cycle RVALID=0, ARREADY=1, mem_cs=0; then a new single read completes normally.
- Single read: ARID=8'h15, ARADDR=32'h0000_0010, ARLEN=0, ARSIZE=2, INCR, SRAM word 4 = 32'hDEAD_BEEF, RREADY=1 → mem_addr=4 at T+1; RVALID=1, RDATA=32'hDEAD_BEEF, RID=8'h15, RLAST=1, RRESP=00 at T+2; ARREADY=1 at T+3.
- INCR burst with backpressure:
  - ARADDR=0x20, ARLEN=3, words 8..11 = 1,2,3,4; RREADY low for 3 cycles on beat 2.
  - Expected: beats 1,2,3,4 in order; beat 2 held stable while stalled; RLAST only on beat 4; mem_addr sequence 8,9,10,11.
- FIXED burst: ARBURST=00, ARLEN=2, ARADDR=0x40 → three beats, all with mem_addr=16 and the same data; RLAST on beat 3.
- Wrap and maximum length: ARADDR word 2^MEM_AW-2, ARLEN=15 → mem_addr sequence 16382, 16383, 0, 1, …, 13; exactly 16 beats; RLAST on the 16th beat.
- Size error: ARSIZE=3, ARLEN=1 → mem_cs never asserted; 2 beats with RRESP=10 and RDATA=0; RLAST on beat 2; then IDLE.
